// File: rtl/drum_voice_mixer.sv
// Polyphonic drum playback: one ROM address counter per voice; the active voices are summed with saturation.
// The mixed sample registers one cycle after sample_tick. There is no backpressure: tick and trig are free-running strobes.
module drum_voice_mixer #(
  parameter int ADDR_W     = 12,
  parameter int LEN0       = 2450,
  parameter int LEN1       = 485,
  parameter int LEN2       = 3210,
  parameter int LEN3       = 728,
  parameter int LEN4       = 2028,
  parameter int GAIN_SHIFT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic [4:0]          trig,
  input  logic [39:0]         rom_data,
  output logic [5*ADDR_W-1:0] rom_addr,
  output logic [7:0]          sample_out,
  output logic                sample_valid,
  output logic [4:0]          voice_active
);
  localparam int NV = 5;

  function automatic logic [ADDR_W-1:0] last_addr(input int v);
    case (v)
      0:       return ADDR_W'(LEN0);
      1:       return ADDR_W'(LEN1);
      2:       return ADDR_W'(LEN2);
      3:       return ADDR_W'(LEN3);
      default: return ADDR_W'(LEN4);
    endcase
  endfunction

  logic [ADDR_W-1:0] addr_q [NV];
  logic [ADDR_W-1:0] addr_d [NV];
  logic [NV-1:0]     active_q, active_d;
  logic [NV-1:0]     data_ok_q, data_ok_d;
  logic [7:0]        sample_q, sample_d;
  logic              valid_q, valid_d;
  logic signed [10:0] sum, shifted;
  logic [7:0]        mixed;

  // data_ok drops for the cycle after any address move, covering the registered ROM's read latency.
  always_comb begin : voice_next
    for (int i = 0; i < NV; i++) begin
      addr_d[i]    = addr_q[i];
      active_d[i]  = active_q[i];
      data_ok_d[i] = 1'b1;
      if (trig[i]) begin
        addr_d[i]    = '0;
        active_d[i]  = 1'b1;
        data_ok_d[i] = 1'b0;
      end else if (sample_tick && active_q[i]) begin
        data_ok_d[i] = 1'b0;
        if (addr_q[i] == last_addr(i)) begin
          active_d[i] = 1'b0;
          addr_d[i]   = '0;
        end else begin
          addr_d[i] = addr_q[i] + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin : mix
    sum = '0;
    for (int i = 0; i < NV; i++) begin
      if (active_q[i] && data_ok_q[i]) begin
        sum = sum + ($signed({3'b000, rom_data[8*i +: 8]}) - 11'sd128);
      end
    end
    shifted = sum >>> GAIN_SHIFT;
    if (shifted > 11'sd127) begin
      mixed = 8'd255;
    end else if (shifted < -11'sd128) begin
      mixed = 8'd0;
    end else begin
      mixed = {~shifted[7], shifted[6:0]};
    end
    sample_d = sample_tick ? mixed : sample_q;
    valid_d  = sample_tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NV; i++) addr_q[i] <= '0;
      active_q  <= '0;
      data_ok_q <= '0;
      sample_q  <= 8'd128;
      valid_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NV; i++) addr_q[i] <= addr_d[i];
      active_q  <= active_d;
      data_ok_q <= data_ok_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
    end
  end

  for (genvar g = 0; g < NV; g++) begin : g_addr
    assign rom_addr[g*ADDR_W +: ADDR_W] = addr_q[g];
  end

  assign voice_active = active_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
endmodule

// File: tb/tb_drum_voice_mixer.sv
// Bench for drum_voice_mixer: a registered ROM model plus a voice-level reference model.
// The reference model tracks a sample position and a readiness cycle per voice.
module tb_drum_voice_mixer;
  localparam int GS = 1;
  localparam int LEN [5] = '{2450, 485, 3210, 728, 2028};

  logic        clk;
  logic        rst;
  logic        sample_tick;
  logic [4:0]  trig;
  logic [39:0] rom_data;
  logic [59:0] rom_addr;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic [4:0]  voice_active;

  drum_voice_mixer dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .trig(trig),
    .rom_data(rom_data), .rom_addr(rom_addr), .sample_out(sample_out),
    .sample_valid(sample_valid), .voice_active(voice_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ROM contents: either a fixed byte per voice or an address-dependent pattern.
  bit       rom_const = 1'b1;
  logic [7:0] cbyte [5] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};

  function automatic logic [7:0] rom_fn(input int v, input int a);
    logic [31:0] t;
    if (rom_const) return cbyte[v];
    t = ((a * 29 + v * 71 + (a >> 4) * 13) ^ (a >> 2));
    return t[7:0];
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 5; i++)
      rom_data[8*i +: 8] <= rom_fn(i, int'(rom_addr[12*i +: 12]));

  // Reference model: state as it should appear after the next clock edge.
  bit m_act   [5];
  int m_pos   [5];
  int m_ready [5];
  int m_out   = 128;
  bit m_valid = 1'b0;
  int cyc     = 0;

  task automatic model_step(input bit r, input logic [4:0] tg, input bit tk);
    int s;
    if (r) begin
      for (int i = 0; i < 5; i++) begin
        m_act[i] = 1'b0;
        m_pos[i] = 0;
      end
      m_out   = 128;
      m_valid = 1'b0;
    end else begin
      if (tk) begin
        s = 0;
        for (int i = 0; i < 5; i++)
          if (m_act[i] && cyc >= m_ready[i]) s += int'(rom_fn(i, m_pos[i])) - 128;
        s = s >>> GS;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        m_out = s + 128;
      end
      m_valid = tk;
      for (int i = 0; i < 5; i++) begin
        if (tg[i]) begin
          m_act[i]   = 1'b1;
          m_pos[i]   = 0;
          m_ready[i] = cyc + 2;
        end else if (tk && m_act[i]) begin
          if (m_pos[i] == LEN[i]) begin
            m_act[i] = 1'b0;
            m_pos[i] = 0;
          end else begin
            m_pos[i]++;
          end
          m_ready[i] = cyc + 2;
        end
      end
    end
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input logic [4:0] tg, input bit tk);
    @(negedge clk);
    rst = r;
    trig = tg;
    sample_tick = tk;
    model_step(r, tg, tk);
    chk_en = 1'b1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic set_all(input logic [7:0] b);
    for (int i = 0; i < 5; i++) cbyte[i] = b;
  endtask

  // Compare process: every cycle, shortly after the edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      logic [4:0] ea;
      for (int i = 0; i < 5; i++) begin
        ea[i] = m_act[i];
        chk($sformatf("addr%0d", i), int'(rom_addr[12*i +: 12]), m_pos[i]);
      end
      chk("voice_active", int'(voice_active), int'(ea));
      chk("sample_valid", int'(sample_valid), int'(m_valid));
      chk("sample_out", int'(sample_out), m_out);
    end
  end

  initial begin
    int n, maxa, gap;
    logic [4:0] tg;
    bit tk;
    rst = 1'b1; trig = '0; sample_tick = 1'b0;
    step(1, 0, 0);
    step(1, 0, 0);

    // Idle ticks
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1);
      after_edge();
      chk("idle_out", int'(sample_out), 128);
      chk("idle_vld", int'(sample_valid), 1);
      chk("idle_act", int'(voice_active), 0);
      step(0, 0, 0);
      after_edge();
      chk("idle_vld_low", int'(sample_valid), 0);
    end

    // Hihat: one voice, full length
    cbyte[1] = 8'hC0;
    step(0, 5'b00010, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    after_edge();
    chk("hihat_first", int'(sample_out), 160);
    chk("hihat_model", m_out, 160);
    chk("hihat_active", int'(voice_active), 5'b00010);
    n = 1;
    maxa = int'(rom_addr[23:12]);
    while (voice_active[1] && n < 600) begin
      step(0, 0, 0);
      step(0, 0, 1);
      after_edge();
      n++;
      if (int'(rom_addr[23:12]) > maxa) maxa = int'(rom_addr[23:12]);
    end
    chk("hihat_ticks", n, 486);
    chk("hihat_maxaddr", maxa, 485);
    chk("hihat_addr_end", int'(rom_addr[23:12]), 0);

    // Saturation, both rails
    step(1, 0, 0);
    set_all(8'hFF);
    step(0, 5'h1F, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    after_edge();
    chk("sat_hi", int'(sample_out), 255);
    set_all(8'h00);
    step(0, 0, 0);
    step(0, 0, 1);
    after_edge();
    chk("sat_lo", int'(sample_out), 0);

    // Gain shift with two voices
    step(1, 0, 0);
    set_all(8'h80);
    cbyte[0] = 8'hA0;
    cbyte[2] = 8'hA0;
    step(0, 5'b00101, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    after_edge();
    chk("gain", int'(sample_out), 160);
    chk("gain_model", m_out, 160);

    // Retrigger voice 3 on a tick cycle, then a stale-data tick
    step(1, 0, 0);
    set_all(8'h80);
    cbyte[3] = 8'hF0;
    step(0, 5'b01000, 0);
    repeat (300) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end
    after_edge();
    chk("v3_at300", int'(rom_addr[47:36]), 300);
    step(0, 5'b01000, 1);
    after_edge();
    chk("retrig_addr", int'(rom_addr[47:36]), 0);
    chk("retrig_act", int'(voice_active), 5'b01000);
    chk("retrig_mix", int'(sample_out), 184);
    step(0, 0, 0);
    step(0, 0, 1);
    after_edge();
    chk("retrig_ready", int'(sample_out), 184);
    step(0, 5'b01000, 0);
    step(0, 0, 1);
    after_edge();
    chk("stale_gate", int'(sample_out), 128);

    // Reset mid-playback, with a tick in the same cycle
    step(1, 0, 0);
    set_all(8'hB0);
    step(0, 5'b10001, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    after_edge();
    chk("pre_rst_act", int'(voice_active), 5'b10001);
    step(1, 0, 1);
    after_edge();
    chk("rst_act", int'(voice_active), 0);
    chk("rst_addr_nz", int'(rom_addr != '0), 0);
    chk("rst_out", int'(sample_out), 128);
    chk("rst_vld", int'(sample_valid), 0);

    // Random: dense triggers over patterned ROM
    rom_const = 1'b0;
    step(1, 0, 0);
    gap = 2;
    repeat (8000) begin
      tk = (gap >= 2) && ($urandom_range(0, 1) == 0);
      for (int i = 0; i < 5; i++) tg[i] = ($urandom_range(0, 49) == 0);
      step(($urandom_range(0, 1999) == 0), tg, tk);
      gap = tk ? 1 : gap + 1;
    end

    // Random: long plays so every voice reaches its end
    step(0, 5'h1F, 0);
    gap = 1;
    repeat (15000) begin
      tk = (gap >= 2) && ($urandom_range(0, 1) == 0);
      for (int i = 0; i < 5; i++) tg[i] = ($urandom_range(0, 2999) == 0);
      step(0, tg, tk);
      gap = tk ? 1 : gap + 1;
    end
    step(0, 0, 0);
    after_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/drum_voice_mixer.md
Name: drum_voice_mixer

Overview:
Polyphonic playback engine between the trigger sources (debounced buttons / loop sequencer) and pwm_dac. It replaces single-voice playback with one address counter per drum voice, so overlapping hits play together instead of being dropped. It drives one address bus per drum ROM, sums the returned 8-bit offset-binary samples with saturation, and presents one 8-bit sample per sample_tick to pwm_dac.

Parameters:
ADDR_W, 12, ROM address width per voice
LEN0, 2450, last address of voice 0 (cymbal)
LEN1, 485, last address of voice 1 (hihat)
LEN2, 3210, last address of voice 2 (tom)
LEN3, 728, last address of voice 3 (snare)
LEN4, 2028, last address of voice 4 (kick)
GAIN_SHIFT, 1, arithmetic right shift applied to the signed sum before saturation (0..3)

Ports:
clk  in  1  system clock (48 MHz)
rst  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle strobe at the sample rate (14.5 kHz)
trig  in  5  one-cycle trigger per voice; bit i = voice i
rom_data  in  40  ROM outputs; byte i = voice i, offset-binary, registered ROM (1-cycle read latency)
rom_addr  out  60  address per voice; field i = bits [12i+11:12i]
sample_out  out  8  mixed sample, offset-binary (128 = silence)
sample_valid  out  1  one-cycle strobe when sample_out updates
voice_active  out  5  bit i high while voice i is playing

Behaviour:
- Reset (synchronous, active-high): all rom_addr = 0, voice_active = 0, data_ok = 0, sample_out = 128, sample_valid = 0. Reset mid-playback silences every voice on the next edge.
- Per-voice state: addr (ADDR_W), active, data_ok. data_ok = 1 means rom_data byte i corresponds to the current addr. data_ok clears on every addr change and sets the following cycle.
- Trigger: trig[i] in cycle T -> addr_i = 0, active_i = 1, data_ok_i = 0 at T+1. A trigger on an already active voice restarts it (retrigger). A trigger has priority over a tick advance in the same cycle; that voice does not advance on that tick.
- Tick, per voice with active_i=1 and no trig[i]: if addr_i == LENi, set active_i = 0 and addr_i = 0. Otherwise addr_i increments by 1.
- Mix on the sample_tick cycle uses pre-edge register values. contrib_i = (active_i && data_ok_i) ? (rom_data_i − 128) as signed 9-bit : 0.
- Sum: 11-bit signed (range −640..635). Then arithmetic shift right by GAIN_SHIFT. Then saturate to −128..127 and add 128.
- sample_out and sample_valid register at T+1 for a tick at T; latency is 1 cycle. sample_valid is high for exactly one cycle per tick. sample_out holds between ticks.
- No voice active -> sample_out = 128 on each tick.
- A voice reaching LENi contributes its last sample on that tick and is silent from the next tick.
- Ticks with no active voice still produce sample_valid.
- Simultaneous triggers on several voices all start in the same cycle.
- Invariant: ticks are at least 2 cycles apart. The data_ok gating guarantees stale ROM data is never summed after a retrigger.

Test Plan:
- Reset, then 3 ticks with no triggers -> sample_out = 128, sample_valid pulses once per tick at T+1, voice_active = 0.
- trig = 5'b00010, rom_data byte1 = 0xC0, GAIN_SHIFT=0 -> on the next tick sample_out = 0xC0. voice_active[1] falls on the tick after addr reaches 485. rom_addr field1 steps 0..485 then returns to 0.
- trig = 5'b11111 with all bytes = 0xFF, GAIN_SHIFT=0 -> sum 635, sample_out saturates to 255. With all bytes = 0x00 -> sample_out = 0.
- GAIN_SHIFT=1, voices 0 and 2 active with bytes 0xA0 and 0xA0 -> (32+32)>>1 = 32 -> sample_out = 160.
- Voice 3 at addr 300, then trig[3] asserted in the same cycle as sample_tick -> addr3 = 0 (not 301). The first tick after has contrib 0 if data_ok is not yet set, otherwise the byte for addr 0.
- rst asserted while voices 0, 4 are active -> next cycle: voice_active = 0, all addresses 0, sample_out = 128, no sample_valid.
